// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Register-file client for the 8-bit processor datapath. Decoded instructions
// arrive over a valid/ready handshake. The block drives the regfile read
// ports, forwards same-cycle write-back data, and holds the captured operands
// in a registered output stage for the execute stage. It also owns the
// regfile write port, which is fed from the write-back bus. A pending-write
// scoreboard stalls any instruction that would read, or overwrite, a
// register whose write-back is still outstanding.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      instruction handshake (in_ready is combinational)
//   in_rs1, in_rs2, in_rd  source and destination register addresses
//   in_wen                 instruction writes in_rd
//   out_valid/out_ready    operand bundle handshake toward execute
//   out_op1, out_op2       captured operand values
//   out_rd, out_wen        destination and write flag, passed through
//   wb_valid/addr/data     write-back bus (no backpressure)
//   regwrite, wa, wd       regfile write port
//   ra1, ra2 / rd1, rd2    regfile read addresses / combinational read data
//   busy                   scoreboard, bit n = write to register n pending
//   stall_cnt              saturating count of stalled input cycles
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter  int DW = 8,
    parameter  int AW = 3,
    localparam int NR = 1 << AW
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic [AW-1:0] in_rd,
    input  logic          in_wen,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_op1,
    output logic [DW-1:0] out_op2,
    output logic [AW-1:0] out_rd,
    output logic          out_wen,

    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,

    output logic          regwrite,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,

    output logic [NR-1:0] busy,
    output logic [15:0]   stall_cnt
);

    logic          clr1;
    logic          clr2;
    logic          clrd;
    logic          haz;
    logic          accept;
    logic          stall;
    logic [DW-1:0] op1_src;
    logic [DW-1:0] op2_src;
    logic [NR-1:0] busy_next;

    // The regfile ports are plain wiring. The write enable is gated with
    // rst_n so that a write-back in flight when reset asserts never lands.
    assign ra1      = in_rs1;
    assign ra2      = in_rs2;
    assign regwrite = wb_valid & rst_n;
    assign wa       = wb_addr;
    assign wd       = wb_data;

    // Match each register the instruction touches against the write-back
    // bus. A match does two things. It selects wb_data over the regfile value,
    // which would still be stale this cycle. It also releases the matching
    // scoreboard bit early, so a dependent instruction issues in the very
    // cycle its producer writes back.
    always_comb begin
        clr1    = wb_valid & (wb_addr == in_rs1);
        clr2    = wb_valid & (wb_addr == in_rs2);
        clrd    = wb_valid & (wb_addr == in_rd);
        op1_src = clr1 ? wb_data : rd1;
        op2_src = clr2 ? wb_data : rd2;
    end

    // A hazard exists if either source is still pending (RAW). A hazard also
    // exists if the destination is pending and this instruction writes it
    // (WAW). The WAW check keeps a single busy bit sufficient per register.
    // in_ready also needs room in the output stage: the stage must be empty,
    // or draining this cycle.
    always_comb begin
        haz = (busy[in_rs1] & ~clr1)
            | (busy[in_rs2] & ~clr2)
            | (in_wen & busy[in_rd] & ~clrd);
        in_ready = ~haz & (~out_valid | out_ready);
        accept   = in_valid & in_ready;
        stall    = in_valid & ~in_ready;
    end

    // Next scoreboard value. Apply the write-back clear first, then the new
    // reservation. When both hit the same register, the set wins, because
    // the newly accepted instruction still owes a write. A write-back to an
    // idle register simply clears an already-clear bit.
    always_comb begin
        busy_next = busy;
        if (wb_valid) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (accept && in_wen) begin
            busy_next[in_rd] = 1'b1;
        end
    end

    // Registered output stage. An accept loads a fresh bundle. This covers
    // the case where the old bundle drains in the same cycle, which gives
    // one bundle per cycle at full throughput. A drain with no accept only
    // drops out_valid and leaves the data fields as they were. Under
    // backpressure nothing here changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op1   <= op1_src;
            out_op2   <= op2_src;
            out_rd    <= in_rd;
            out_wen   <= in_wen;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Pending-write scoreboard. Reset drops every reservation, because the
    // instructions that owned them are discarded along with the held bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Stall counter. It counts cycles where an instruction was offered but
    // could not be taken, for either reason (hazard or full output stage).
    // It sticks at all-ones rather than wrapping, so a long stall never
    // looks short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//
// Bench for operand_fetch. It contains:
//   - a behavioural regfile attached to the DUT's regfile ports;
//   - a reference model of the architectural registers, the pending writes
//     and the output slot;
//   - a scoreboard queue of expected operand bundles, which a separate
//     monitor consumes.
// Directed sequences walk through the documented scenarios, a randomized
// phase follows, and a long stall exercises counter saturation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_operand_fetch;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_rs1 = '0;
    logic [AW-1:0] in_rs2 = '0;
    logic [AW-1:0] in_rd = '0;
    logic          in_wen = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_op1;
    logic [DW-1:0] out_op2;
    logic [AW-1:0] out_rd;
    logic          out_wen;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          regwrite;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [NR-1:0] busy;
    logic [15:0]   stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_fetch #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_wen(out_wen),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .regwrite(regwrite), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    // Behavioural regfile. It writes on the clock edge from the DUT's write
    // port and reads combinationally.
    logic [DW-1:0] rf [NR] = '{default: '0};
    always @(posedge clk) if (regwrite) rf[wa] <= wd;
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    // One comparison. Every check funnels through this task so that the
    // counters stay in one place.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model state. It holds the architectural register values,
    // the set of registers owed a write, whether the output slot is occupied,
    // and the stall tally.
    typedef struct {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [AW-1:0] rd;
        logic          wen;
    } bundle_t;

    bundle_t       exp_q[$];
    logic [DW-1:0] mregs [NR] = '{default: '0};
    bit            pending [NR];
    bit            slot_full = 1'b0;
    int            m_stall = 0;

    bit            m_haz;
    bit            m_rdy;
    bit            m_acc;
    logic [NR-1:0] pend_vec;
    bundle_t       nb;

    function automatic bit wbHits(input logic [AW-1:0] r);
        return wb_valid && (wb_addr == r);
    endfunction

    // Model process. At each falling edge it checks the combinational and
    // registered outputs against the model. It then predicts what the coming
    // rising edge will do. The inputs are stable between this falling edge
    // and that rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("regwrite_in_reset", 32'(regwrite), 0);
            checkOutput("busy_in_reset", 32'(busy), 0);
            checkOutput("out_valid_in_reset", 32'(out_valid), 0);
            foreach (pending[i]) pending[i] = 1'b0;
            slot_full = 1'b0;
            m_stall   = 0;
            exp_q.delete();
        end else begin
            m_haz = (pending[in_rs1] && !wbHits(in_rs1))
                 || (pending[in_rs2] && !wbHits(in_rs2))
                 || (in_wen && pending[in_rd] && !wbHits(in_rd));
            m_rdy = !m_haz && (!slot_full || out_ready);
            m_acc = in_valid && m_rdy;
            foreach (pending[i]) pend_vec[i] = pending[i];

            checkOutput("in_ready", 32'(in_ready), 32'(m_rdy));
            checkOutput("busy", 32'(busy), 32'(pend_vec));
            checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            checkOutput("out_valid", 32'(out_valid), 32'(slot_full));
            checkOutput("ra1", 32'(ra1), 32'(in_rs1));
            checkOutput("ra2", 32'(ra2), 32'(in_rs2));
            checkOutput("regwrite", 32'(regwrite), 32'(wb_valid));
            if (wb_valid) begin
                checkOutput("wa", 32'(wa), 32'(wb_addr));
                checkOutput("wd", 32'(wd), 32'(wb_data));
            end

            if (m_acc) begin
                nb.op1 = wbHits(in_rs1) ? wb_data : mregs[in_rs1];
                nb.op2 = wbHits(in_rs2) ? wb_data : mregs[in_rs2];
                nb.rd  = in_rd;
                nb.wen = in_wen;
                exp_q.push_back(nb);
                slot_full = 1'b1;
            end else if (out_ready) begin
                slot_full = 1'b0;
            end
            if (in_valid && !m_rdy && m_stall < 65535) m_stall++;
            if (wb_valid) begin
                pending[wb_addr] = 1'b0;
                mregs[wb_addr]   = wb_data;
            end
            if (m_acc && in_wen) pending[in_rd] = 1'b1;
        end
    end

    // Monitor. When the execute stage takes a bundle, the monitor pops the
    // oldest expected bundle and compares every field.
    bundle_t got;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("bundle_unexpected", 32'(out_valid), 0);
            end else begin
                got = exp_q.pop_front();
                checkOutput("out_op1", 32'(out_op1), 32'(got.op1));
                checkOutput("out_op2", 32'(out_op2), 32'(got.op2));
                checkOutput("out_rd", 32'(out_rd), 32'(got.rd));
                checkOutput("out_wen", 32'(out_wen), 32'(got.wen));
            end
        end
    end

    // Drive every input for the coming cycle.
    task automatic applyStimulus(input logic iv, input logic [AW-1:0] rs1,
                                 input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                                 input logic wen, input logic wbv,
                                 input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                                 input logic ordy);
        in_valid  = iv;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_wen    = wen;
        wb_valid  = wbv;
        wb_addr   = wba;
        wb_data   = wbd;
        out_ready = ordy;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0, ordy);
    endtask

    initial begin
        $display("[TB] operand_fetch bench starting");

        // Reset and check the values that come out of reset.
        #1 rst_n = 1'b0;
        idle(1'b1);
        repeat (2) stepClock();
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_op1", 32'(out_op1), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 0);
        rst_n = 1'b1;
        #1 checkOutput("rst_in_ready", 32'(in_ready), 1);
        stepClock();

        // Write back r3=7, then read r3 and r0.
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd3, 8'd7, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
        stepClock();
        checkOutput("fwd_out_valid", 32'(out_valid), 1);
        checkOutput("fwd_out_op1", 32'(out_op1), 7);
        checkOutput("fwd_out_op2", 32'(out_op2), 0);

        // Reserve r4, then stall a reader of r4 until its write-back arrives.
        applyStimulus(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
        #1 checkOutput("raw_in_ready", 32'(in_ready), 0);
        checkOutput("raw_busy", 32'(busy), 32'h10);
        repeat (3) stepClock();
        checkOutput("raw_stall_cnt", 32'(stall_cnt), 3);
        applyStimulus(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 3'd4, 8'd23, 1'b0);
        #1 checkOutput("release_in_ready", 32'(in_ready), 1);
        stepClock();
        checkOutput("release_op1", 32'(out_op1), 23);
        checkOutput("release_busy", 32'(busy), 0);

        // Hold under backpressure for 5 cycles, then release.
        applyStimulus(1'b1, 3'd1, 3'd2, 3'd5, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1 checkOutput("hold_in_ready", 32'(in_ready), 0);
            stepClock();
            checkOutput("hold_out_valid", 32'(out_valid), 1);
            checkOutput("hold_out_op1", 32'(out_op1), 23);
        end
        out_ready = 1'b1;
        #1 checkOutput("unhold_in_ready", 32'(in_ready), 1);
        stepClock();
        checkOutput("unhold_out_rd", 32'(out_rd), 5);
        checkOutput("unhold_out_op1", 32'(out_op1), 0);

        // Clear and set the same busy bit in one cycle: the set wins.
        applyStimulus(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 3'd2, 8'h55, 1'b1);
        #1 checkOutput("setwin_in_ready", 32'(in_ready), 1);
        stepClock();
        checkOutput("setwin_busy", 32'(busy), 32'h04);
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd2, 8'h56, 1'b1);
        stepClock();

        // Assert reset in the middle of a stall with r3 and r4 reserved.
        applyStimulus(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        stepClock();
        checkOutput("pre_rst_busy", 32'(busy), 32'h18);
        checkOutput("pre_rst_out_valid", 32'(out_valid), 1);
        applyStimulus(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 3'd6, 8'h99, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 0);
        checkOutput("mid_rst_regwrite", 32'(regwrite), 0);
        stepClock();
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd4, 3'd6, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
        #1 checkOutput("post_rst_in_ready", 32'(in_ready), 1);
        stepClock();
        checkOutput("post_rst_out_valid", 32'(out_valid), 1);
        checkOutput("post_rst_r6_unwritten", 32'(out_op2), 0);

        // Randomized traffic, checked by the model and the monitor.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                          3'($urandom_range(0, 7)), 8'($urandom),
                          1'($urandom_range(0, 3) != 0));
            stepClock();
        end

        // Long stall to drive the counter into saturation.
        idle(1'b1);
        rst_n = 1'b0;
        stepClock();
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd0, 3'd0, 3'd5, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
        repeat (65600) stepClock();
        checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        checkOutput("sat_busy", 32'(busy), 32'h20);

        idle(1'b1);
        repeat (3) stepClock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
